// File: rtl/synth_pkg.sv
// Shared encodings and default widths for the looper datapath.
package synth_pkg;

    localparam int unsigned ADDR_W_DEF  = 23;
    localparam int unsigned DATA_W_DEF  = 16;
    localparam int unsigned TIMEOUT_DEF = 255;

    typedef enum logic [1:0] {
        MODE_IDLE    = 2'd0,
        MODE_RECORD  = 2'd1,
        MODE_PLAY    = 2'd2,
        MODE_OVERDUB = 2'd3
    } mode_t;

    typedef enum logic [2:0] {
        S_WAIT    = 3'd0,
        S_RD_REQ  = 3'd1,
        S_RD_WAIT = 3'd2,
        S_WR_REQ  = 3'd3,
        S_WR_WAIT = 3'd4
    } state_t;

endpackage

// File: rtl/loop_sequencer_sat_add.sv
// Signed saturating adder used to mix live input into the stored loop.
module sat_add
    import synth_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] sum_c
);

    localparam logic [DATA_W-1:0] POS_MAX = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic [DATA_W-1:0] NEG_MIN = {1'b1, {(DATA_W-1){1'b0}}};

    logic [DATA_W:0] wide;

    // One extra bit of headroom; clamp when the top two bits disagree.
    always_comb begin
        wide  = {a[DATA_W-1], a} + {b[DATA_W-1], b};
        sum_c = wide[DATA_W-1:0];
        if (wide[DATA_W] != wide[DATA_W-1]) begin
            sum_c = wide[DATA_W] ? NEG_MIN : POS_MAX;
        end
    end

endmodule

// File: rtl/loop_sequencer.sv
// Record/playback/overdub looper issuing one RAM read and/or write per sample tick.
module loop_sequencer
    import synth_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = DATA_W_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sample_tick,
    input  logic [DATA_W-1:0] sample_in,
    input  logic              rec,
    input  logic              play,
    input  logic              stop,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_valid,
    output logic              ram_req,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ack,
    output logic [1:0]        mode,
    output logic [ADDR_W-1:0] loop_len,
    output logic              overrun
);

    localparam int unsigned TO_W = $clog2(TIMEOUT + 1);

    state_t            state;
    mode_t             mode_q;
    logic [ADDR_W-1:0] pointer;
    logic [ADDR_W-1:0] len_q;
    logic [DATA_W-1:0] sample_reg;
    logic              pend_stop;
    logic              pend_rec;
    logic              pend_play;
    logic [TO_W-1:0]   to_cnt;

    mode_t             wait_mode;
    logic [ADDR_W-1:0] wait_ptr;
    logic [ADDR_W-1:0] wait_len;
    logic [ADDR_W-1:0] ptr_inc;
    logic [ADDR_W-1:0] ptr_wrap;
    logic              to_expired;
    logic [DATA_W-1:0] mix;

    assign mode     = mode_q;
    assign loop_len = len_q;

    // Live input mixed with the word just read back from the loop.
    sat_add #(
        .DATA_W (DATA_W)
    ) u_sat_add (
        .a     (sample_out),
        .b     (sample_reg),
        .sum_c (mix)
    );

    // Resolve live and latched mode commands (stop > rec > play) for use in S_WAIT.
    always_comb begin
        wait_mode = mode_q;
        wait_ptr  = pointer;
        wait_len  = len_q;
        if (stop || pend_stop) begin
            wait_mode = MODE_IDLE;
            if (mode_q == MODE_RECORD) begin
                wait_len = pointer;
            end
        end else if (rec || pend_rec) begin
            if (len_q != '0) begin
                wait_mode = MODE_OVERDUB;
            end else begin
                wait_mode = MODE_RECORD;
            end
            wait_ptr = '0;
        end else if (play || pend_play) begin
            if (len_q != '0) begin
                wait_mode = MODE_PLAY;
                wait_ptr  = '0;
            end
        end
    end

    // Pointer step helpers and ack-timeout detect.
    always_comb begin
        ptr_inc    = pointer + ADDR_W'(1);
        ptr_wrap   = (ptr_inc == len_q) ? '0 : ptr_inc;
        to_expired = (to_cnt == TO_W'(TIMEOUT - 1));
    end

    // Transaction sequencer, mode register and all registered outputs.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state        <= S_WAIT;
            mode_q       <= MODE_IDLE;
            pointer      <= '0;
            len_q        <= '0;
            sample_reg   <= '0;
            pend_stop    <= 1'b0;
            pend_rec     <= 1'b0;
            pend_play    <= 1'b0;
            to_cnt       <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
            ram_req      <= 1'b0;
            ram_we       <= 1'b0;
            ram_addr     <= '0;
            ram_wdata    <= '0;
            overrun      <= 1'b0;
        end else begin
            sample_valid <= 1'b0;

            if (state == S_WAIT) begin
                pend_stop <= 1'b0;
                pend_rec  <= 1'b0;
                pend_play <= 1'b0;
            end else begin
                pend_stop <= pend_stop | stop;
                pend_rec  <= pend_rec | rec;
                pend_play <= pend_play | play;
            end

            if (sample_tick && (state != S_WAIT)) begin
                overrun <= 1'b1;
            end

            case (state)
                S_WAIT: begin
                    mode_q  <= wait_mode;
                    pointer <= wait_ptr;
                    len_q   <= wait_len;
                    if (sample_tick) begin
                        sample_reg <= sample_in;
                        case (wait_mode)
                            MODE_RECORD:  state <= S_WR_REQ;
                            MODE_PLAY:    state <= S_RD_REQ;
                            MODE_OVERDUB: state <= S_RD_REQ;
                            default:      state <= S_WAIT;
                        endcase
                    end
                end

                S_RD_REQ: begin
                    ram_req  <= 1'b1;
                    ram_we   <= 1'b0;
                    ram_addr <= pointer;
                    to_cnt   <= '0;
                    state    <= S_RD_WAIT;
                end

                S_RD_WAIT: begin
                    if (ram_ack) begin
                        ram_req      <= 1'b0;
                        sample_out   <= ram_rdata;
                        sample_valid <= 1'b1;
                        if (mode_q == MODE_OVERDUB) begin
                            state <= S_WR_REQ;
                        end else begin
                            pointer <= ptr_wrap;
                            state   <= S_WAIT;
                        end
                    end else if (to_expired) begin
                        ram_req <= 1'b0;
                        overrun <= 1'b1;
                        state   <= S_WAIT;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end

                S_WR_REQ: begin
                    ram_req  <= 1'b1;
                    ram_we   <= 1'b1;
                    ram_addr <= pointer;
                    if (mode_q == MODE_OVERDUB) begin
                        ram_wdata <= mix;
                    end else begin
                        ram_wdata <= sample_reg;
                    end
                    to_cnt <= '0;
                    state  <= S_WR_WAIT;
                end

                S_WR_WAIT: begin
                    if (ram_ack) begin
                        ram_req <= 1'b0;
                        state   <= S_WAIT;
                        if (mode_q == MODE_RECORD) begin
                            // Full memory ends the recording and starts playback.
                            if (pointer == '1) begin
                                len_q   <= '1;
                                mode_q  <= MODE_PLAY;
                                pointer <= '0;
                            end else begin
                                pointer <= ptr_inc;
                            end
                        end else begin
                            pointer <= ptr_wrap;
                        end
                    end else if (to_expired) begin
                        ram_req <= 1'b0;
                        overrun <= 1'b1;
                        state   <= S_WAIT;
                    end else begin
                        to_cnt <= to_cnt + TO_W'(1);
                    end
                end

                default: state <= S_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_loop_sequencer.sv
// Directed bench for loop_sequencer with a behavioural looper model and a RAM controller model.
module tb_loop_sequencer;

    typedef struct packed {
        logic        we;
        logic [3:0]  addr;
        logic [15:0] data;
    } txn_t;

    logic        clk;
    logic        rst;
    logic        sample_tick;
    logic [15:0] sample_in;
    logic        rec;
    logic        play;
    logic        stop;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        ram_req;
    logic        ram_we;
    logic [3:0]  ram_addr;
    logic [15:0] ram_wdata;
    logic [15:0] ram_rdata;
    logic        ram_ack;
    logic [1:0]  mode;
    logic [3:0]  loop_len;
    logic        overrun;

    int checks = 0;
    int passes = 0;

    loop_sequencer #(
        .ADDR_W  (4),
        .DATA_W  (16),
        .TIMEOUT (255)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_tick  (sample_tick),
        .sample_in    (sample_in),
        .rec          (rec),
        .play         (play),
        .stop         (stop),
        .sample_out   (sample_out),
        .sample_valid (sample_valid),
        .ram_req      (ram_req),
        .ram_we       (ram_we),
        .ram_addr     (ram_addr),
        .ram_wdata    (ram_wdata),
        .ram_rdata    (ram_rdata),
        .ram_ack      (ram_ack),
        .mode         (mode),
        .loop_len     (loop_len),
        .overrun      (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic note_fail(input string name);
        checks++;
        $display("FAIL %s: event occurred, expected none", name);
    endtask

    // ---------------- RAM controller model (acks 5 cycles after req) ----------------
    logic [15:0] ram_mem [16];
    bit          ram_mute = 1'b0;
    int          rcnt = 0;
    bit          rdone = 1'b0;

    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            ram_ack = 1'b0;
            rcnt    = 0;
            rdone   = 1'b0;
        end else begin
            ram_ack = 1'b0;
            if (ram_req !== 1'b1) begin
                rcnt  = 0;
                rdone = 1'b0;
            end else if (!rdone && !ram_mute) begin
                rcnt++;
                if (rcnt == 5) begin
                    ram_ack = 1'b1;
                    rdone   = 1'b1;
                    if (ram_we) ram_mem[ram_addr] = ram_wdata;
                    else        ram_rdata = ram_mem[ram_addr];
                end
            end
        end
    end

    // ---------------- behavioural looper model ----------------
    int          m_mode = 0;
    int          m_len  = 0;
    int          m_ptr  = 0;
    logic [15:0] m_mem [16];
    txn_t        exp_txn [$];
    logic [15:0] exp_smp [$];

    function automatic logic [15:0] sat16(input logic [15:0] a, input logic [15:0] b);
        int s;
        s = int'($signed(a)) + int'($signed(b));
        if (s > 32767) s = 32767;
        else if (s < -32768) s = -32768;
        return 16'(s);
    endfunction

    function automatic txn_t mk_txn(input logic we, input int addr, input logic [15:0] data);
        txn_t t;
        t.we   = we;
        t.addr = 4'(addr);
        t.data = data;
        return t;
    endfunction

    task automatic model_cmd(input int c);
        if (c == 0) begin
            if (m_mode == 1) m_len = m_ptr;
            m_mode = 0;
        end else if (c == 1) begin
            m_mode = (m_len != 0) ? 3 : 1;
            m_ptr  = 0;
        end else if (m_len != 0) begin
            m_mode = 2;
            m_ptr  = 0;
        end
    endtask

    task automatic model_tick(input logic [15:0] s);
        logic [15:0] v;
        case (m_mode)
            1: begin
                exp_txn.push_back(mk_txn(1'b1, m_ptr, s));
                m_mem[m_ptr] = s;
                if (m_ptr == 15) begin
                    m_len = 15; m_mode = 2; m_ptr = 0;
                end else m_ptr++;
            end
            2: begin
                exp_txn.push_back(mk_txn(1'b0, m_ptr, 16'h0));
                exp_smp.push_back(m_mem[m_ptr]);
                m_ptr = (m_ptr + 1) % m_len;
            end
            3: begin
                exp_txn.push_back(mk_txn(1'b0, m_ptr, 16'h0));
                exp_smp.push_back(m_mem[m_ptr]);
                v = sat16(m_mem[m_ptr], s);
                exp_txn.push_back(mk_txn(1'b1, m_ptr, v));
                m_mem[m_ptr] = v;
                m_ptr = (m_ptr + 1) % m_len;
            end
            default: ;
        endcase
    endtask

    task automatic model_reset();
        m_mode = 0; m_len = 0; m_ptr = 0;
        exp_txn.delete();
        exp_smp.delete();
    endtask

    // ---------------- compare process ----------------
    bit   prev_req = 1'b0;
    txn_t held;
    txn_t cur;
    int   n_txn = 0;
    int   n_valid = 0;

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            if (ram_req && !prev_req) begin
                n_txn++;
                held = mk_txn(ram_we, int'(ram_addr), ram_wdata);
                if (exp_txn.size() == 0) note_fail("unexpected_txn");
                else begin
                    cur = exp_txn.pop_front();
                    chk("txn_we", 32'(ram_we), 32'(cur.we));
                    chk("txn_addr", 32'(ram_addr), 32'(cur.addr));
                    if (cur.we) chk("txn_wdata", 32'(ram_wdata), 32'(cur.data));
                end
            end else if (ram_req) begin
                chk("req_stable", 32'({ram_we, ram_addr, ram_wdata}), 32'(held));
            end
            if (sample_valid) begin
                n_valid++;
                if (exp_smp.size() == 0) note_fail("unexpected_sample_valid");
                else chk("sample_out", 32'(sample_out), 32'(exp_smp.pop_front()));
            end
        end
        prev_req = (ram_req === 1'b1);
    end

    // ---------------- stimulus helpers ----------------
    task automatic settle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_cmd(input int c);
        @(negedge clk);
        stop = (c == 0); rec = (c == 1); play = (c == 2);
        @(negedge clk);
        stop = 1'b0; rec = 1'b0; play = 1'b0;
        model_cmd(c);
    endtask

    task automatic do_tick(input logic [15:0] s, input bit use_model);
        @(negedge clk);
        sample_tick = 1'b1;
        sample_in   = s;
        if (use_model) model_tick(s);
        @(negedge clk);
        sample_tick = 1'b0;
    endtask

    task automatic wait_req(input string name);
        int n = 0;
        while (ram_req !== 1'b1 && n < 12) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(ram_req), 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int nv0;
        int nt0;
        int cnt;
        rst = 1'b0; sample_tick = 1'b0; sample_in = '0;
        rec = 1'b0; play = 1'b0; stop = 1'b0;
        ram_ack = 1'b0; ram_rdata = '0;
        for (int i = 0; i < 16; i++) begin
            ram_mem[i] = '0;
            m_mem[i]   = '0;
        end

        // 1: reset held with activity on the inputs
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk("reset_ctrl", 32'({sample_valid, ram_req, ram_we, mode, loop_len, overrun, ram_addr}), 32'd0);
                chk("reset_data", {sample_out, ram_wdata}, 32'd0);
            end
            sample_tick = (i < 2);
            rec         = (i == 0);
            sample_in   = 16'h1234;
        end
        @(negedge clk);
        sample_tick = 1'b0; rec = 1'b0; rst = 1'b1;
        settle(2);

        // 2: record six samples then stop
        pulse_cmd(1);
        settle(2);
        chk("s2_mode_record", 32'(mode), 32'd1);
        for (int i = 1; i <= 6; i++) begin
            do_tick(16'(i), 1'b1);
            settle(20);
        end
        pulse_cmd(0);
        settle(3);
        chk("s2_loop_len", 32'(loop_len), 32'd6);
        chk("s2_mode", 32'(mode), 32'd0);
        chk("s2_loop_len_model", 32'(loop_len), 32'(m_len));
        for (int i = 0; i < 6; i++) chk("s2_ram_word", 32'(ram_mem[i]), 32'(i + 1));

        // 3: play eight ticks, wrapping after six
        nv0 = n_valid;
        pulse_cmd(2);
        for (int i = 0; i < 8; i++) begin
            do_tick(16'h1000 + 16'(i), 1'b1);
            settle(20);
        end
        chk("s3_valid_count", 32'(n_valid - nv0), 32'd8);
        chk("s3_last_sample", 32'(sample_out), 32'd2);
        chk("s3_mode", 32'(mode), 32'd2);
        pulse_cmd(0);
        settle(2);
        chk("s3_mode_stop", 32'(mode), 32'd0);

        // 4: overdub with positive saturation and a negative sum
        pulse_cmd(1);
        settle(2);
        chk("s4_mode_overdub", 32'(mode), 32'd3);
        do_tick(16'h7FFF, 1'b1);
        settle(20);
        do_tick(16'hFFFD, 1'b1);
        settle(20);
        chk("s4_mem0_sat", 32'(ram_mem[0]), 32'h7FFF);
        chk("s4_mem1_neg", 32'(ram_mem[1]), 32'hFFFF);
        chk("s4_overrun", 32'(overrun), 32'd0);
        pulse_cmd(0);
        settle(2);
        chk("s4_loop_len_kept", 32'(loop_len), 32'd6);

        // 6: reset while a read is outstanding
        pulse_cmd(2);
        do_tick(16'h0, 1'b1);
        wait_req("s6_req_open");
        rst = 1'b0;
        @(negedge clk);
        chk("s6_req_dropped", 32'(ram_req), 32'd0);
        chk("s6_mode", 32'(mode), 32'd0);
        chk("s6_loop_len", 32'(loop_len), 32'd0);
        rst = 1'b1;
        model_reset();
        settle(2);
        chk("s6_overrun_clear", 32'(overrun), 32'd0);

        // 5a: ack timeout during a record write
        pulse_cmd(1);
        settle(2);
        chk("s5_mode_record", 32'(mode), 32'd1);
        ram_mute = 1'b1;
        exp_txn.push_back(mk_txn(1'b1, 0, 16'd9));
        do_tick(16'd9, 1'b0);
        wait_req("s5_timeout_req");
        cnt = 0;
        while (ram_req === 1'b1 && cnt < 400) begin
            cnt++;
            @(negedge clk);
        end
        chk("s5_timeout_cycles", 32'(cnt), 32'd255);
        chk("s5_timeout_overrun", 32'(overrun), 32'd1);
        ram_mute = 1'b0;
        settle(2);
        do_tick(16'd10, 1'b1);
        settle(20);
        chk("s5_ptr_not_advanced", 32'(ram_mem[0]), 32'd10);

        // 5b: second tick while the write is still open
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        settle(2);
        chk("s5b_overrun_clear", 32'(overrun), 32'd0);
        pulse_cmd(1);
        nt0 = n_txn;
        do_tick(16'd5, 1'b1);
        @(negedge clk);
        sample_tick = 1'b1;
        sample_in   = 16'd99;
        @(negedge clk);
        sample_tick = 1'b0;
        settle(20);
        chk("s5b_overrun", 32'(overrun), 32'd1);
        chk("s5b_one_write", 32'(n_txn - nt0), 32'd1);
        pulse_cmd(0);
        settle(2);
        chk("s5b_loop_len", 32'(loop_len), 32'd1);
        chk("s5b_ram_word", 32'(ram_mem[0]), 32'd5);

        chk("exp_txn_drained", 32'(exp_txn.size()), 32'd0);
        chk("exp_smp_drained", 32'(exp_smp.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
